// File: rtl/led_pkg.sv
// -----------------------------------------------------------------------------
// led_pkg
// Shared definitions for the LED signal conditioner.
//   WD_CND_CNT   : width of the per-channel debounce/stretch counter
//   cond_state_t : per-channel conditioning state
// Optional feature macro used by the files that import this package:
//   LED_SIG_COND_STRETCH_EN - enables the post-release stretch state.
// -----------------------------------------------------------------------------
package led_pkg;

    localparam int WD_CND_CNT = 24;

    typedef enum logic [2:0] {
        S_LOW     = 3'd0,
        S_RISE    = 3'd1,
        S_HIGH    = 3'd2,
        S_FALL    = 3'd3,
        S_STRETCH = 3'd4
    } cond_state_t;

endpackage

// File: rtl/led_sig_cond_ch.sv
// -----------------------------------------------------------------------------
// led_sig_cond_ch
// One conditioning channel: 2-flop synchroniser, debounce FSM with a shared
// cycle counter, registered level output and a one-cycle glitch pulse.
// Configuration macro: LED_SIG_COND_STRETCH_EN (adds the post-release
// stretch state and the NB_STRETCH_CYC parameter).
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   raw    in  1  raw status line, asynchronous to clk
//   level  out 1  conditioned level (registered)
//   glitch out 1  one-cycle pulse when a debounce attempt is rejected
// -----------------------------------------------------------------------------
module led_sig_cond_ch
    import led_pkg::*;
#(
    parameter logic [WD_CND_CNT-1:0] NB_DEB_CYC     = 24'd1000
`ifdef LED_SIG_COND_STRETCH_EN
   ,parameter logic [WD_CND_CNT-1:0] NB_STRETCH_CYC = 24'd10000000
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic glitch
);

    // Terminal counts; the compare fires one cycle before the counter would
    // reach the parameter value, so cnt never needs to hold 2^24-1 + 1.
    localparam logic [WD_CND_CNT-1:0] DEB_LAST = NB_DEB_CYC - 24'd1;
`ifdef LED_SIG_COND_STRETCH_EN
    localparam logic [WD_CND_CNT-1:0] STR_LAST = NB_STRETCH_CYC - 24'd1;
`endif

    logic [1:0]            sync_q;
    logic                  sync;
    cond_state_t           state;
    logic [WD_CND_CNT-1:0] cnt;

    assign sync = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
            state  <= S_LOW;
            cnt    <= '0;
            level  <= 1'b0;
            glitch <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            glitch <= 1'b0;
            case (state)
                S_LOW: begin
                    if (sync) begin
                        state <= S_RISE;
                        cnt   <= '0;
                    end
                end
                S_RISE: begin
                    if (!sync) begin
                        state  <= S_LOW;
                        glitch <= 1'b1;
                    end else if (cnt == DEB_LAST) begin
                        state <= S_HIGH;
                        level <= 1'b1;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
                S_HIGH: begin
                    if (!sync) begin
                        state <= S_FALL;
                        cnt   <= '0;
                    end
                end
                S_FALL: begin
                    if (sync) begin
                        state  <= S_HIGH;
                        glitch <= 1'b1;
                    end else if (cnt == DEB_LAST) begin
`ifdef LED_SIG_COND_STRETCH_EN
                        state <= S_STRETCH;
                        cnt   <= '0;
`else
                        state <= S_LOW;
                        level <= 1'b0;
`endif
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
`ifdef LED_SIG_COND_STRETCH_EN
                S_STRETCH: begin
                    // A return to high here is a genuine re-assertion, not a
                    // bounce, so it is not counted as a glitch.
                    if (sync) begin
                        state <= S_HIGH;
                    end else if (cnt == STR_LAST) begin
                        state <= S_LOW;
                        level <= 1'b0;
                    end else begin
                        cnt <= cnt + 24'd1;
                    end
                end
`endif
                default: begin
                    state <= S_LOW;
                    level <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/led_sig_cond.sv
// -----------------------------------------------------------------------------
// led_sig_cond
// Per-channel signal conditioner feeding the LED driver monitor bus, plus a
// shared saturating counter of rejected glitches.
// Configuration macro: LED_SIG_COND_STRETCH_EN (post-release stretch; when
// undefined NB_STRETCH_CYC only takes part in the parameter range check).
// Ports:
//   i_sys_clk             in  1            system clock
//   i_sys_resetn          in  1            asynchronous active-low reset
//   i_raw_signal          in  WD_LED_NUMB  raw status lines (asynchronous)
//   o_bus_monitor_signal  out WD_LED_NUMB  conditioned level per channel
//   m_err_cond_info       out WD_ERR_INFO  saturating glitch count
// -----------------------------------------------------------------------------
module led_sig_cond
    import led_pkg::*;
#(
    parameter int                    WD_LED_NUMB    = 5,
    parameter logic [WD_CND_CNT-1:0] NB_DEB_CYC     = 24'd1000,
    parameter logic [WD_CND_CNT-1:0] NB_STRETCH_CYC = 24'd10000000,
    parameter int                    WD_ERR_INFO    = 4
) (
    input  logic                   i_sys_clk,
    input  logic                   i_sys_resetn,
    input  logic [WD_LED_NUMB-1:0] i_raw_signal,
    output logic [WD_LED_NUMB-1:0] o_bus_monitor_signal,
    output logic [WD_ERR_INFO-1:0] m_err_cond_info
);

    // Zero-length debounce or stretch would underflow the terminal count.
    if (NB_DEB_CYC == '0 || NB_STRETCH_CYC == '0) begin : g_bad_param
        $error("led_sig_cond: NB_DEB_CYC and NB_STRETCH_CYC must be >= 1");
    end

    localparam logic [WD_ERR_INFO-1:0] ERR_MAX = {WD_ERR_INFO{1'b1}};
    localparam logic [WD_ERR_INFO-1:0] ERR_ONE = {{(WD_ERR_INFO-1){1'b0}}, 1'b1};

    logic [WD_LED_NUMB-1:0] glitch;

    for (genvar gi = 0; gi < WD_LED_NUMB; gi++) begin : g_ch
        led_sig_cond_ch #(
            .NB_DEB_CYC     (NB_DEB_CYC)
`ifdef LED_SIG_COND_STRETCH_EN
           ,.NB_STRETCH_CYC (NB_STRETCH_CYC)
`endif
        ) u_ch (
            .clk    (i_sys_clk),
            .rst_n  (i_sys_resetn),
            .raw    (i_raw_signal[gi]),
            .level  (o_bus_monitor_signal[gi]),
            .glitch (glitch[gi])
        );
    end

    // Simultaneous glitches on several channels count as a single event.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            m_err_cond_info <= '0;
        end else if (|glitch && m_err_cond_info != ERR_MAX) begin
            m_err_cond_info <= m_err_cond_info + ERR_ONE;
        end
    end

endmodule

// File: tb/tb_led_sig_cond.sv
// -----------------------------------------------------------------------------
// tb_led_sig_cond
// Directed bench for led_sig_cond with NB_DEB_CYC=4, NB_STRETCH_CYC=8.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_led_sig_cond;

    localparam int          N   = 5;
    localparam logic [23:0] DEB = 24'd4;
    localparam logic [23:0] STR = 24'd8;
`ifdef LED_SIG_COND_STRETCH_EN
    localparam int FALL_LAT = 14;
    localparam bit STR_EN   = 1'b1;
`else
    localparam int FALL_LAT = 6;
    localparam bit STR_EN   = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] raw;
        int           high_cyc;
        logic [N-1:0] exp_seen;
        logic [3:0]   exp_err;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] raw = '0;
    logic [N-1:0] o;
    logic [3:0]   err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    led_sig_cond #(
        .WD_LED_NUMB    (N),
        .NB_DEB_CYC     (DEB),
        .NB_STRETCH_CYC (STR),
        .WD_ERR_INFO    (4)
    ) dut (
        .i_sys_clk            (clk),
        .i_sys_resetn         (rst_n),
        .i_raw_signal         (raw),
        .o_bus_monitor_signal (o),
        .m_err_cond_info      (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        raw   = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic glitch_pulse(input logic [N-1:0] pat);
        raw = pat;
        repeat (2) step();
        raw = '0;
        repeat (8) step();
    endtask

    vec_t       vecs[7];
    logic [N-1:0] seen;
    logic [3:0] exp_err;

    initial begin
        vecs[0] = '{raw: 5'b00010, high_cyc: 2, exp_seen: 5'b00000, exp_err: 4'd1};
        vecs[1] = '{raw: 5'b01100, high_cyc: 2, exp_seen: 5'b00000, exp_err: 4'd2};
        vecs[2] = '{raw: 5'b10000, high_cyc: 3, exp_seen: 5'b00000, exp_err: 4'd3};
        vecs[3] = '{raw: 5'b00001, high_cyc: 4, exp_seen: 5'b00000, exp_err: 4'd4};
        vecs[4] = '{raw: 5'b00100, high_cyc: 5, exp_seen: 5'b00100, exp_err: 4'd4};
        vecs[5] = '{raw: 5'b00010, high_cyc: 6, exp_seen: 5'b00010, exp_err: 4'd4};
        vecs[6] = '{raw: 5'b11111, high_cyc: 1, exp_seen: 5'b00000, exp_err: 4'd5};

        // Reset state
        do_reset();
        chk("reset_o", o, 0);
        chk("reset_err", err, 0);

        // Clean rise on ch0: sampled at edge 0, high after edge 6
        raw = 5'b00001;
        for (int k = 0; k <= 8; k++) begin
            step();
            chk("rise_o", o, (k >= 6) ? 5'b00001 : 5'b00000);
        end

        // Release on ch0
        raw = 5'b00000;
        for (int k = 0; k <= 16; k++) begin
            step();
            chk("release_o", o, (k < FALL_LAT) ? 5'b00001 : 5'b00000);
        end
        chk("release_err", err, 0);

        // Retrigger: raw returns high at edge 10 of the release
        raw = 5'b00001;
        repeat (10) step();
        chk("retrig_pre_o", o, 5'b00001);
        raw = 5'b00000;
        for (int k = 0; k <= 24; k++) begin
            if (k == 10) raw = 5'b00001;
            step();
            if (STR_EN) chk("retrig_o", o[0], 1);
            else        chk("retrig_o", o[0], (k < 6 || k >= 16) ? 1 : 0);
        end
        chk("retrig_err", err, 0);

        // Table: pulses of various widths, cumulative error count
        do_reset();
        for (int i = 0; i < 7; i++) begin
            seen = '0;
            raw  = vecs[i].raw;
            for (int c = 0; c < vecs[i].high_cyc; c++) begin
                step();
                seen |= o;
            end
            raw = '0;
            for (int c = 0; c < 30; c++) begin
                step();
                seen |= o;
            end
            chk($sformatf("vec%0d_seen", i), seen, vecs[i].exp_seen);
            chk($sformatf("vec%0d_err", i), err, vecs[i].exp_err);
            chk($sformatf("vec%0d_idle", i), o, 0);
        end

        // Saturation: 20 sequential glitches on ch3
        exp_err = 4'd5;
        for (int i = 0; i < 20; i++) begin
            glitch_pulse(5'b01000);
            exp_err = (exp_err == 4'hF) ? 4'hF : exp_err + 4'd1;
            chk($sformatf("sat%0d_err", i), err, exp_err);
        end
        repeat (10) step();
        chk("sat_hold_err", err, 4'hF);

        // Async reset while ch0 is stretching with err=3
        do_reset();
        repeat (3) glitch_pulse(5'b00010);
        chk("arst_pre_err", err, 3);
        raw = 5'b00001;
        repeat (8) step();
        raw = 5'b00000;
        repeat (9) step();
        chk("arst_pre_o", o, STR_EN ? 5'b00001 : 5'b00000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_o", o, 0);
        chk("arst_err", err, 0);
        step();
        rst_n = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
